// File: rtl/dead_time_gen.sv
// dead_time_gen: complementary high/low gate drive from a PWM stream with a programmable dead band and latched fault
module dead_time_gen #(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                pwm_in,
   input  logic                enable_in,
   input  logic [DT_WIDTH-1:0] dt_cycles_in,
   input  logic                fault_in,
   input  logic                fault_clr_in,
   output logic                hs_out,
   output logic                ls_out,
   output logic                dt_active_out,
   output logic                fault_latched_out
);
   typedef enum logic [2:0] {IDLE, DT_TO_HS, HS_ON, DT_TO_LS, LS_ON, FAULT} state_t;
   state_t              state_q, state_d;
   logic [DT_WIDTH-1:0] cnt_q, cnt_d, load;
   logic                pwm_q, rel_q;
   logic                hs_q, ls_q, dta_q, flt_q;
   // Dead band of D cycles needs D-1 in the counter; a request of 0 behaves as 1.
   assign load = (dt_cycles_in == '0) ? '0 : dt_cycles_in - 1'b1;
   // Next-state logic in priority order: fault, fault clear, enable, then PWM tracking.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (fault_in) state_d = FAULT;
      else if (state_q == FAULT) state_d = fault_clr_in ? IDLE : FAULT;
      else if (!enable_in) state_d = IDLE;
      else begin
         case (state_q)
            IDLE: if (rel_q) begin
               state_d = pwm_q ? DT_TO_HS : DT_TO_LS;
               cnt_d   = load;
            end
            HS_ON: if (!pwm_q) begin
               state_d = DT_TO_LS;
               cnt_d   = load;
            end
            LS_ON: if (pwm_q) begin
               state_d = DT_TO_HS;
               cnt_d   = load;
            end
            DT_TO_LS: begin
               if (pwm_q) state_d = HS_ON;
               else if (cnt_q == '0) state_d = LS_ON;
               else cnt_d = cnt_q - 1'b1;
            end
            DT_TO_HS: begin
               if (!pwm_q) state_d = LS_ON;
               else if (cnt_q == '0) state_d = HS_ON;
               else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   // State, counter, sampled PWM and registered outputs; rel_q holds the FSM in IDLE for the
   // first edge after reset so the first decision uses a freshly captured pwm_q.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pwm_q   <= 1'b0;
         rel_q   <= 1'b0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         dta_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_in;
         rel_q   <= 1'b1;
         hs_q    <= state_d == HS_ON;
         ls_q    <= state_d == LS_ON;
         dta_q   <= state_d == DT_TO_HS || state_d == DT_TO_LS;
         flt_q   <= state_d == FAULT;
      end
   end
   assign hs_out            = hs_q;
   assign ls_out            = ls_q;
   assign dt_active_out     = dta_q;
   assign fault_latched_out = flt_q;
endmodule

// File: tb/tb_dead_time_gen.sv
// tb_dead_time_gen: directed checks of dead band timing, short pulses, fault latch and resets
module tb_dead_time_gen;
   logic       clk = 1'b0, rst_n = 1'b0, pwm = 1'b1, en = 1'b1, flt = 1'b0, clr = 1'b0;
   logic [7:0] dt = 8'd4;
   logic       hs, ls, dta, fl;
   int         total = 0, bad = 0;

   always #10 clk = ~clk;

   dead_time_gen #(.DT_WIDTH(8)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .pwm_in(pwm), .enable_in(en),
      .dt_cycles_in(dt), .fault_in(flt), .fault_clr_in(clr),
      .hs_out(hs), .ls_out(ls), .dt_active_out(dta), .fault_latched_out(fl)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic outs(input string tag, input logic h, input logic l, input logic d);
      chk({tag, ".hs"}, hs, h);
      chk({tag, ".ls"}, ls, l);
      chk({tag, ".dt"}, dta, d);
   endtask

   task automatic tick();
      @(negedge clk);
      chk("overlap", hs & ls, 1'b0);
   endtask

   // Toggle pwm to p and follow one full band of d cycles; dt is rewritten to nd mid-band.
   task automatic band(input logic p, input int d, input int nd);
      pwm = p;
      for (int k = 1; k <= d + 2; k++) begin
         tick();
         outs("band", (k == 1) ? !p : ((k == d + 2) ? p : 1'b0),
                      (k == 1) ? p : ((k == d + 2) ? !p : 1'b0),
                      k >= 2 && k <= d + 1);
         if (k == 2) dt = nd[7:0];
      end
   endtask

   // From IDLE with pwm high: d cycles of dead band, then high side on.
   task automatic restart(input int d);
      for (int k = 1; k <= d + 1; k++) begin
         tick();
         outs("restart", k == d + 1, 1'b0, k <= d);
      end
   endtask

   task automatic hold(input int n, input logic h, input logic l);
      for (int k = 0; k < n; k++) begin
         tick();
         outs("hold", h, l, 1'b0);
      end
   endtask

   initial begin
      repeat (3) begin
         tick();
         outs("reset", 1'b0, 1'b0, 1'b0);
         chk("reset.flt", fl, 1'b0);
      end
      #3 rst_n = 1'b1;
      tick();
      outs("rel_idle", 1'b0, 1'b0, 1'b0);
      restart(4);
      dt = 8'd3;
      repeat (2) begin
         band(1'b0, 3, 3);
         hold(15, 1'b0, 1'b1);
         band(1'b1, 3, 3);
         hold(15, 1'b1, 1'b0);
      end
      dt = 8'd0;
      band(1'b0, 1, 0);
      hold(5, 1'b0, 1'b1);
      dt = 8'd255;
      band(1'b1, 255, 255);
      hold(5, 1'b1, 1'b0);
      dt = 8'd3;
      band(1'b0, 3, 10);
      hold(5, 1'b0, 1'b1);
      band(1'b1, 10, 10);
      hold(5, 1'b1, 1'b0);
      dt = 8'd5;
      band(1'b0, 5, 5);
      hold(3, 1'b0, 1'b1);
      pwm = 1'b1;
      tick();
      outs("sp_e0", 1'b0, 1'b1, 1'b0);
      tick();
      outs("sp_dt", 1'b0, 1'b0, 1'b1);
      pwm = 1'b0;
      tick();
      outs("sp_dt2", 1'b0, 1'b0, 1'b1);
      tick();
      outs("sp_ls", 1'b0, 1'b1, 1'b0);
      hold(5, 1'b0, 1'b1);
      band(1'b1, 5, 5);
      hold(2, 1'b1, 1'b0);
      flt = 1'b1;
      clr = 1'b1;
      tick();
      outs("flt_in", 1'b0, 1'b0, 1'b0);
      chk("flt_in.latched", fl, 1'b1);
      tick();
      chk("flt_clr_ignored", fl, 1'b1);
      flt = 1'b0;
      clr = 1'b0;
      tick();
      outs("flt_hold", 1'b0, 1'b0, 1'b0);
      chk("flt_hold.latched", fl, 1'b1);
      clr = 1'b1;
      tick();
      outs("flt_idle", 1'b0, 1'b0, 1'b0);
      chk("flt_idle.latched", fl, 1'b0);
      restart(5);
      clr = 1'b0;
      hold(3, 1'b1, 1'b0);
      en = 1'b0;
      tick();
      outs("en_off", 1'b0, 1'b0, 1'b0);
      tick();
      outs("en_off2", 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      restart(5);
      hold(2, 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1 outs("arst", 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      outs("arst_idle", 1'b0, 1'b0, 1'b0);
      restart(5);
      hold(3, 1'b1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
